// File: rtl/mem_a_read_requester.sv
`default_nettype none
// ============================================================================
// Module      : mem_a_read_requester
// Description : Pops A-operand addresses, issues one line read per address and
//               forwards the returned lines, in order, to the A data FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_a_read_requester #(
    parameter int BUS_WIDTH_BYTES = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        a_fifo_addr,
    input  logic                         a_fifo_empty,
    output logic                         a_fifo_pop,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [BUS_WIDTH_BYTES*8-1:0] mem_rdata,
    output logic [BUS_WIDTH_BYTES*8-1:0] data_out,
    output logic                         data_push,
    input  logic                         data_full,
    output logic                         busy,
    output logic                         err_unexpected
);

    localparam int c_DATA_W = BUS_WIDTH_BYTES * 8;
    localparam int c_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_pop;
    logic                  w_req;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [c_CNT_W-1:0]    r_reserved;
    logic [c_CNT_W-1:0]    r_granted;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_DATA_W-1:0]   r_buf [MAX_OUTSTANDING];
    logic                  r_err;

    logic                  w_buf_empty;
    logic                  w_buf_full;
    logic                  w_push;
    logic                  w_rv_ok;
    logic                  w_rv_err;
    logic                  w_gr_inc;
    logic                  w_gr_dec;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Request FSM: one pop, one settle cycle for the FIFO head, one request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!a_fifo_empty && (r_reserved < c_MAX_CNT)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (mem_gnt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr <= '0;
        end else if (w_pop) begin
            r_mem_addr <= a_fifo_addr;
        end
    end

    // ------------------------------------------------------------------
    // Response acceptance and output strobes
    // ------------------------------------------------------------------
    assign w_buf_empty = (r_count == '0);
    assign w_buf_full  = (r_count == c_MAX_CNT);
    assign w_push      = !w_buf_empty && !data_full;
    // A response is only kept if a granted read is owed and there is room.
    assign w_rv_ok     = mem_rvalid && (r_granted != '0) && !w_buf_full;
    assign w_rv_err    = mem_rvalid && !w_rv_ok;
    assign w_gr_inc    = w_req && mem_gnt;
    assign w_gr_dec    = mem_rvalid && (r_granted != '0);

    // ------------------------------------------------------------------
    // Credit counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reserved <= '0;
            r_granted  <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_err      <= 1'b0;
        end else begin
            case ({w_pop, w_push})
                2'b10:   r_reserved <= r_reserved + c_CNT_ONE;
                2'b01:   r_reserved <= r_reserved - c_CNT_ONE;
                default: r_reserved <= r_reserved;
            endcase

            case ({w_gr_inc, w_gr_dec})
                2'b10:   r_granted <= r_granted + c_CNT_ONE;
                2'b01:   r_granted <= r_granted - c_CNT_ONE;
                default: r_granted <= r_granted;
            endcase

            case ({w_rv_ok, w_push})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_rv_ok) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_push) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end

            if (w_rv_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Line storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_rv_ok) begin
            r_buf[r_wptr] <= mem_rdata;
        end
    end

    assign a_fifo_pop     = w_pop;
    assign mem_req        = w_req;
    assign mem_addr       = r_mem_addr;
    assign data_out       = r_buf[r_rptr];
    assign data_push      = w_push;
    assign busy           = (r_state != ST_IDLE) || (r_reserved != '0) || !w_buf_empty;
    assign err_unexpected = r_err;

endmodule
`default_nettype wire
